// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : game_pkg                                                     |
// | Description : Shared definitions for the tug-of-war game: round sequencer  |
// |               state encoding and default timing constants reused by the    |
// |               score logic and the tests.                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package game_pkg;

  // Round sequencer state encoding
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_GATHER_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC   = 3'd2;
  localparam logic [2:0] ST_FAKE_ENC   = 3'd3;
  localparam logic [2:0] ST_CUE_ENC    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_GATHER = ST_GATHER_ENC,
    S_WAIT   = ST_WAIT_ENC,
    S_FAKE   = ST_FAKE_ENC,
    S_CUE    = ST_CUE_ENC
  } state_t;

  // Default timing constants (in prescaler ticks unless noted)
  localparam int DEF_WAIT_BITS  = 4;  // random delay word width (bits)
  localparam int DEF_MIN_WAIT   = 2;  // minimum pre-cue delay
  localparam int DEF_CUE_TICKS  = 8;  // slow reaction window; fast is half
  localparam int DEF_FAKE_TICKS = 2;  // fake cue lamp duration
  localparam int DEF_MAX_FAKE   = 2;  // consecutive fakes before a forced real cue

endpackage : game_pkg
`default_nettype wire

// File: rtl/rand_gather.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rand_gather                                                  |
// | Description : Serial collector for the random delay word. Shifts one LFSR  |
// |               bit per enabled clock and flags the cycle in which the last  |
// |               bit arrives; the full word is presented combinationally in   |
// |               that cycle so the caller can use it without extra latency.   |
// | Ports       : clk, rst (async, active-low)                                 |
// |               load     - restart collection (bit counter to 0)             |
// |               shift    - accept rand_bit this clock                        |
// |               rand_bit - LFSR delay bit                                    |
// |               word     - {stored bits, rand_bit}, MSB = oldest bit         |
// |               done     - shift active and this is the last bit             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rand_gather #(
  parameter int WAIT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 rand_bit,
  output logic [WAIT_BITS-1:0] word,
  output logic                 done
);

  localparam int CNT_W = $clog2(WAIT_BITS + 1);

  // Only WAIT_BITS-1 bits are stored: the last bit is taken straight from
  // rand_bit in the completing cycle, so the oldest bit never has to be kept
  // beyond the point where the word is consumed.
  logic [WAIT_BITS-2:0] sreg;
  logic [CNT_W-1:0]     cnt;

  assign word = {sreg, rand_bit};
  assign done = shift && (cnt == CNT_W'(WAIT_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      cnt  <= '0;
    end else if (shift) begin
      sreg <= word[WAIT_BITS-2:0];
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule : rand_gather
`default_nettype wire

// File: rtl/cue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cue_scheduler                                                |
// | Description : Round sequencer for the tug-of-war game. Collects a random   |
// |               pre-cue delay, optionally shows fake cues, lights the real   |
// |               cue and judges the player buttons (foul, hit, tie, timeout). |
// | Ports       : clk, rst (async, active-low)                                 |
// |               tick        - time-base strobe from the prescaler            |
// |               start/abort - one-clk round begin / cancel requests          |
// |               rand_bit    - LFSR delay bit                                 |
// |               rand_fake   - LFSR fake-cue select                           |
// |               rand_speed  - LFSR window-speed select                       |
// |               btn_l/btn_r - debounced one-clk press pulses                 |
// |               cue, fake_cue, fast, busy                 - status/lamps     |
// |               hit_l/r, foul_l/r, round_done             - one-clk results  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cue_scheduler
  import game_pkg::*;
#(
  parameter int WAIT_BITS  = DEF_WAIT_BITS,
  parameter int MIN_WAIT   = DEF_MIN_WAIT,
  parameter int CUE_TICKS  = DEF_CUE_TICKS,
  parameter int FAKE_TICKS = DEF_FAKE_TICKS,
  parameter int MAX_FAKE   = DEF_MAX_FAKE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic start,
  input  logic abort,
  input  logic rand_bit,
  input  logic rand_fake,
  input  logic rand_speed,
  input  logic btn_l,
  input  logic btn_r,
  output logic cue,
  output logic fake_cue,
  output logic fast,
  output logic busy,
  output logic hit_l,
  output logic hit_r,
  output logic foul_l,
  output logic foul_r,
  output logic round_done
);

  // One extra bit so word + MIN_WAIT cannot overflow
  localparam int DLY_W   = WAIT_BITS + 1;
  localparam int WIN_MAX = (CUE_TICKS > FAKE_TICKS) ? CUE_TICKS : FAKE_TICKS;
  localparam int WIN_W   = $clog2(WIN_MAX + 1);
  localparam int FC_W    = (MAX_FAKE < 1) ? 1 : $clog2(MAX_FAKE + 1);

  state_t             state, state_n;
  logic [DLY_W-1:0]   delay_cnt, delay_n;
  logic [WIN_W-1:0]   win_cnt, win_n;
  logic [FC_W-1:0]    fake_cnt, fake_cnt_n;
  logic               fake_sel, fake_sel_n;
  logic               cue_n, fake_cue_n, fast_n, busy_n;
  logic               hit_l_n, hit_r_n, foul_l_n, foul_r_n, round_done_n;

  logic               gather_load, gather_shift, gather_done;
  logic [WAIT_BITS-1:0] gather_word;

  rand_gather #(
    .WAIT_BITS (WAIT_BITS)
  ) u_rand_gather (
    .clk      (clk),
    .rst      (rst),
    .load     (gather_load),
    .shift    (gather_shift),
    .rand_bit (rand_bit),
    .word     (gather_word),
    .done     (gather_done)
  );

  // Next-state and registered-output logic. Priority: abort, then presses,
  // then tick-driven expiry.
  always_comb begin
    state_n      = state;
    delay_n      = delay_cnt;
    win_n        = win_cnt;
    fake_cnt_n   = fake_cnt;
    fake_sel_n   = fake_sel;
    cue_n        = cue;
    fake_cue_n   = fake_cue;
    fast_n       = fast;
    hit_l_n      = 1'b0;
    hit_r_n      = 1'b0;
    foul_l_n     = 1'b0;
    foul_r_n     = 1'b0;
    round_done_n = 1'b0;
    gather_load  = 1'b0;
    gather_shift = 1'b0;

    if (abort) begin
      state_n    = S_IDLE;
      cue_n      = 1'b0;
      fake_cue_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_n     = S_GATHER;
            gather_load = 1'b1;
            fake_cnt_n  = '0;
          end
        end

        S_GATHER, S_WAIT, S_FAKE: begin
          if (btn_l || btn_r) begin
            // Any press before the real cue is a foul
            state_n      = S_IDLE;
            foul_l_n     = btn_l;
            foul_r_n     = btn_r;
            round_done_n = 1'b1;
            cue_n        = 1'b0;
            fake_cue_n   = 1'b0;
          end else if (state == S_GATHER) begin
            gather_shift = 1'b1;
            if (gather_done) begin
              state_n    = S_WAIT;
              delay_n    = {1'b0, gather_word} + DLY_W'(MIN_WAIT);
              fast_n     = rand_speed;
              fake_sel_n = rand_fake && (fake_cnt != FC_W'(MAX_FAKE));
            end
          end else if (tick) begin
            if (state == S_WAIT) begin
              if (delay_cnt <= DLY_W'(1)) begin
                if (fake_sel) begin
                  state_n    = S_FAKE;
                  fake_cue_n = 1'b1;
                  fake_cnt_n = fake_cnt + FC_W'(1);
                  win_n      = WIN_W'(FAKE_TICKS);
                end else begin
                  state_n = S_CUE;
                  cue_n   = 1'b1;
                  win_n   = fast ? WIN_W'(CUE_TICKS / 2) : WIN_W'(CUE_TICKS);
                end
              end else begin
                delay_n = delay_cnt - DLY_W'(1);
              end
            end else begin
              // FAKE: when the window runs out, roll a fresh delay
              if (win_cnt <= WIN_W'(1)) begin
                state_n     = S_GATHER;
                fake_cue_n  = 1'b0;
                gather_load = 1'b1;
                win_n       = '0;
              end else begin
                win_n = win_cnt - WIN_W'(1);
              end
            end
          end
        end

        S_CUE: begin
          if (btn_l || btn_r) begin
            // Simultaneous presses are a tie: round ends with no winner
            state_n      = S_IDLE;
            hit_l_n      = btn_l && !btn_r;
            hit_r_n      = btn_r && !btn_l;
            round_done_n = 1'b1;
            cue_n        = 1'b0;
          end else if (tick) begin
            if (win_cnt <= WIN_W'(1)) begin
              state_n      = S_IDLE;
              round_done_n = 1'b1;
              cue_n        = 1'b0;
              win_n        = '0;
            end else begin
              win_n = win_cnt - WIN_W'(1);
            end
          end
        end

        default: begin
          state_n    = S_IDLE;
          cue_n      = 1'b0;
          fake_cue_n = 1'b0;
        end
      endcase
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      delay_cnt  <= '0;
      win_cnt    <= '0;
      fake_cnt   <= '0;
      fake_sel   <= 1'b0;
      cue        <= 1'b0;
      fake_cue   <= 1'b0;
      fast       <= 1'b0;
      busy       <= 1'b0;
      hit_l      <= 1'b0;
      hit_r      <= 1'b0;
      foul_l     <= 1'b0;
      foul_r     <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= state_n;
      delay_cnt  <= delay_n;
      win_cnt    <= win_n;
      fake_cnt   <= fake_cnt_n;
      fake_sel   <= fake_sel_n;
      cue        <= cue_n;
      fake_cue   <= fake_cue_n;
      fast       <= fast_n;
      busy       <= busy_n;
      hit_l      <= hit_l_n;
      hit_r      <= hit_r_n;
      foul_l     <= foul_l_n;
      foul_r     <= foul_r_n;
      round_done <= round_done_n;
    end
  end

endmodule : cue_scheduler
`default_nettype wire

// File: tb/tb_cue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cue_scheduler                                             |
// | Description : Directed self-checking bench for cue_scheduler. Inputs are   |
// |               driven 1 ns after the rising edge and outputs are checked    |
// |               1 ns after the following rising edge.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cue_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic tick, start, abort, rand_bit, rand_fake, rand_speed, btn_l, btn_r;
  logic cue, fake_cue, fast, busy, hit_l, hit_r, foul_l, foul_r, round_done;

  int n_checks = 0;
  int n_fails  = 0;

  logic [8:0] outs;
  assign outs = {cue, fake_cue, fast, busy, hit_l, hit_r, foul_l, foul_r, round_done};

  always #5 clk = ~clk;

  cue_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .abort      (abort),
    .rand_bit   (rand_bit),
    .rand_fake  (rand_fake),
    .rand_speed (rand_speed),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .cue        (cue),
    .fake_cue   (fake_cue),
    .fast       (fast),
    .busy       (busy),
    .hit_l      (hit_l),
    .hit_r      (hit_r),
    .foul_l     (foul_l),
    .foul_r     (foul_r),
    .round_done (round_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // One clock with the currently driven inputs; one-clk strobes are cleared after.
  task automatic do_cycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    tick  = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      do_cycle();
    end
  endtask

  task automatic begin_round();
    start = 1'b1;
    do_cycle();
    repeat (4) do_cycle();
  endtask

  initial begin
    logic [3:0] pat;
    rst = 1'b0; tick = 0; start = 0; abort = 0;
    rand_bit = 0; rand_fake = 0; rand_speed = 0; btn_l = 0; btn_r = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'h0);
    rst = 1'b1;
    do_cycle();

    // Presses in IDLE are ignored
    btn_l = 1'b1; btn_r = 1'b1;
    do_cycle();
    check("idle_btn", 32'(outs), 32'h0);

    // Test 1: delay word 1111 -> 17 ticks, then async reset mid-CUE
    rand_bit = 1'b1; rand_fake = 1'b0; rand_speed = 1'b0;
    start = 1'b1;
    do_cycle();
    check("t1_busy", 32'(busy), 32'h1);
    repeat (4) do_cycle();
    tick_n(16);
    check("t1_no_cue_16", 32'(cue), 32'h0);
    tick_n(1);
    check("t1_cue_fast", 32'({cue, fast}), 32'h2);
    tick_n(7);
    check("t1_cue_held", 32'({cue, round_done}), 32'h2);
    #2 rst = 1'b0;
    #1;
    check("t1_async_reset", 32'(outs), 32'h0);
    do_cycle();
    rst = 1'b1;
    do_cycle();

    // Test 2: delay 2, fast window 4, right-player hit on third cue tick
    rand_bit = 1'b0; rand_fake = 1'b0; rand_speed = 1'b1;
    begin_round();
    tick_n(1);
    check("t2_no_cue", 32'(cue), 32'h0);
    tick_n(1);
    check("t2_cue_fast", 32'({cue, fast}), 32'h3);
    tick_n(2);
    btn_r = 1'b1; tick = 1'b1;
    do_cycle();
    check("t2_hit_r", 32'({hit_l, hit_r, round_done, cue, busy}), 32'b01100);
    do_cycle();
    check("t2_pulse_end", 32'({hit_r, round_done}), 32'h0);

    // Test 3: two fake cues then a forced real cue, timeout after 8 ticks
    rand_bit = 1'b0; rand_fake = 1'b1; rand_speed = 1'b0;
    begin_round();
    for (int k = 0; k < 2; k++) begin
      tick_n(2);
      check($sformatf("t3_fake%0d_on", k), 32'({cue, fake_cue}), 32'b01);
      tick_n(1);
      check($sformatf("t3_fake%0d_held", k), 32'(fake_cue), 32'h1);
      tick_n(1);
      check($sformatf("t3_fake%0d_off", k), 32'({fake_cue, busy}), 32'b01);
      repeat (4) do_cycle();
    end
    tick_n(2);
    check("t3_forced_real", 32'({cue, fake_cue, fast}), 32'b100);
    tick_n(7);
    check("t3_window_held", 32'({cue, round_done}), 32'b10);
    tick_n(1);
    check("t3_timeout", 32'({cue, round_done, hit_l, hit_r, busy}), 32'b01000);

    // Test 4: foul during WAIT, tie in CUE, double foul in GATHER
    rand_fake = 1'b0;
    begin_round();
    tick_n(1);
    btn_l = 1'b1;
    do_cycle();
    check("t4_foul_l", 32'({foul_l, foul_r, round_done, busy}), 32'b1010);
    begin_round();
    tick_n(2);
    check("t4_cue_on", 32'(cue), 32'h1);
    btn_l = 1'b1; btn_r = 1'b1;
    do_cycle();
    check("t4_tie", 32'({hit_l, hit_r, round_done, cue, busy}), 32'b00100);
    start = 1'b1;
    do_cycle();
    btn_l = 1'b1; btn_r = 1'b1;
    do_cycle();
    check("t4_double_foul", 32'({foul_l, foul_r, round_done, busy}), 32'b1110);

    // Test 5: press on the expiry tick is a hit; abort beats a press
    rand_speed = 1'b1;
    begin_round();
    tick_n(2);
    tick_n(3);
    check("t5_cue_last", 32'(cue), 32'h1);
    btn_l = 1'b1; tick = 1'b1;
    do_cycle();
    check("t5_hit_l", 32'({hit_l, hit_r, round_done, cue}), 32'b1010);
    begin_round();
    tick_n(1);
    abort = 1'b1; btn_r = 1'b1;
    do_cycle();
    check("t5_abort", 32'({foul_r, round_done, busy, cue}), 32'b0000);
    check("t5_fast_hold", 32'(fast), 32'h1);
    tick_n(3);
    check("t5_idle_ticks", 32'({cue, busy}), 32'b00);

    // Test 6: start while busy and ticks in GATHER do not disturb the delay
    rand_speed = 1'b0; rand_fake = 1'b0;
    pat = 4'b1010;  // oldest bit first -> word 10 -> delay 12
    start = 1'b1;
    do_cycle();
    for (int i = 0; i < 4; i++) begin
      rand_bit = pat[3-i];
      tick = 1'b1;
      if (i == 1) start = 1'b1;
      do_cycle();
    end
    start = 1'b1;
    do_cycle();
    tick_n(11);
    check("t6_no_cue_11", 32'(cue), 32'h0);
    tick_n(1);
    check("t6_cue_12", 32'(cue), 32'h1);
    abort = 1'b1;
    do_cycle();
    check("t6_abort_cue", 32'({cue, busy, round_done}), 32'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_cue_scheduler
`default_nettype wire
